// File: rtl/filter_capture_ctrl.sv
// Filter capture sequencer: skip N samples, write a window to the test RAM, stream it back out.
// Latency: write visible 1 cycle after filter_valid; each readout word takes 3 cycles (addr, latch, hold).
// Backpressure: rd_data/rd_valid held in RD_HOLD until rd_ready; abort cancels from any busy state.
module filter_capture_ctrl #(
  parameter int SIZE_FILTER_DATA   = 16,
  parameter int SIZE_DELAY         = 7,
  parameter int SIZE_TEST_RAM_ADDR = 7,
  // Must not exceed SIZE_FILTER_DATA; the ramp is zero-extended into the RAM word.
  parameter int SIZE_TEST_COUNTER  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_trig,
  input  logic                          i_abort,
  input  logic [SIZE_DELAY-1:0]         i_delay,
  input  logic [SIZE_TEST_RAM_ADDR-1:0] i_length,
  input  logic                          i_test_mode,
  input  logic [SIZE_FILTER_DATA-1:0]   i_filter_data,
  input  logic                          i_filter_valid,
  output logic                          o_ram_we,
  output logic [SIZE_TEST_RAM_ADDR-1:0] o_ram_addr,
  output logic [SIZE_FILTER_DATA-1:0]   o_ram_wdata,
  input  logic [SIZE_FILTER_DATA-1:0]   i_ram_rdata,
  output logic [SIZE_FILTER_DATA-1:0]   o_rd_data,
  output logic                          o_rd_valid,
  input  logic                          i_rd_ready,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_trig_lost
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WR_LAST  = 3'd3,
    S_RD_ADDR  = 3'd4,
    S_RD_LATCH = 3'd5,
    S_RD_HOLD  = 3'd6
  } state_t;

  localparam logic [SIZE_TEST_RAM_ADDR-1:0] ADDR_ONE  = 1;
  localparam logic [SIZE_DELAY-1:0]         DELAY_ONE = 1;
  localparam logic [SIZE_TEST_COUNTER-1:0]  TCNT_ONE  = 1;

  state_t                        r_state;
  logic [SIZE_DELAY-1:0]         r_delay_cnt;
  logic [SIZE_TEST_RAM_ADDR-1:0] r_length;
  logic                          r_test_mode;
  logic [SIZE_TEST_RAM_ADDR-1:0] r_wr_ptr;
  logic [SIZE_TEST_RAM_ADDR-1:0] r_rd_ptr;
  logic [SIZE_TEST_COUNTER-1:0]  r_tcnt;
  logic                          r_ram_we;
  logic [SIZE_TEST_RAM_ADDR-1:0] r_ram_addr;
  logic [SIZE_FILTER_DATA-1:0]   r_ram_wdata;
  logic [SIZE_FILTER_DATA-1:0]   r_rd_data;
  logic                          r_rd_valid;
  logic                          r_done;
  logic                          r_trig_lost;
  logic [SIZE_FILTER_DATA-1:0]   w_capture_data;

  // Sample source for the RAM write: live filter output or the zero-extended test ramp.
  assign w_capture_data = r_test_mode ? SIZE_FILTER_DATA'(r_tcnt) : i_filter_data;

  // Sequencer: all RAM and readout outputs are registered here.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_delay_cnt <= '0;
      r_length    <= '0;
      r_test_mode <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tcnt      <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_trig_lost <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      // A trig seen in any busy state is dropped and reported, even alongside abort.
      r_trig_lost <= i_trig && (r_state != S_IDLE);

      if (i_abort && (r_state != S_IDLE)) begin
        // Abort wins over everything else; RAM contents are left as-is.
        r_state    <= S_IDLE;
        r_ram_we   <= 1'b0;
        r_rd_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ram_we <= 1'b0;
            if (i_trig && !i_abort) begin
              r_delay_cnt <= i_delay;
              r_length    <= i_length;
              r_test_mode <= i_test_mode;
              r_wr_ptr    <= '0;
              r_rd_ptr    <= '0;
              r_tcnt      <= '0;
              // A filter_valid in the trig cycle is intentionally not consumed.
              r_state     <= (i_delay == '0) ? S_CAPTURE : S_DELAY;
            end
          end

          S_DELAY: begin
            if (i_filter_valid) begin
              r_delay_cnt <= r_delay_cnt - DELAY_ONE;
              // The sample taking the count to zero is still a skipped one.
              if (r_delay_cnt == DELAY_ONE) begin
                r_state <= S_CAPTURE;
              end
            end
          end

          S_CAPTURE: begin
            r_ram_we <= i_filter_valid;
            if (i_filter_valid) begin
              r_ram_addr  <= r_wr_ptr;
              r_ram_wdata <= w_capture_data;
              r_tcnt      <= r_tcnt + TCNT_ONE;
              if (r_wr_ptr == r_length) begin
                r_state <= S_WR_LAST;
              end else begin
                r_wr_ptr <= r_wr_ptr + ADDR_ONE;
              end
            end
          end

          S_WR_LAST: begin
            // Final write lands this cycle; read address is set up for the next.
            r_ram_we   <= 1'b0;
            r_ram_addr <= r_rd_ptr;
            r_state    <= S_RD_ADDR;
          end

          S_RD_ADDR: begin
            r_state <= S_RD_LATCH;
          end

          S_RD_LATCH: begin
            r_rd_data  <= i_ram_rdata;
            r_rd_valid <= 1'b1;
            r_state    <= S_RD_HOLD;
          end

          S_RD_HOLD: begin
            if (i_rd_ready) begin
              r_rd_valid <= 1'b0;
              if (r_rd_ptr == r_length) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_rd_ptr   <= r_rd_ptr + ADDR_ONE;
                r_ram_addr <= r_rd_ptr + ADDR_ONE;
                r_state    <= S_RD_ADDR;
              end
            end
          end

          default: begin
            r_state    <= S_IDLE;
            r_ram_we   <= 1'b0;
            r_rd_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_trig_lost = r_trig_lost;

endmodule

// File: tb/tb_filter_capture_ctrl.sv
// Bench for filter_capture_ctrl: directed scenarios with a scoreboard of expected RAM writes and readout words.
// A RAM model with one-cycle read latency sits on the RAM port.
// A monitor process pops and compares on every ram_we, readout handshake and done pulse.
module tb_filter_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trig = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  delay = '0;
  logic [6:0]  length = '0;
  logic        test_mode = 1'b0;
  logic [15:0] filter_data = '0;
  logic        filter_valid = 1'b0;
  logic        ram_we;
  logic [6:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        trig_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;
  logic mon_en = 1'b0;
  logic prev_fv = 1'b0;
  logic [22:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem [0:127];

  filter_capture_ctrl #(
    .SIZE_FILTER_DATA(16), .SIZE_DELAY(7), .SIZE_TEST_RAM_ADDR(7), .SIZE_TEST_COUNTER(16)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_trig(trig), .i_abort(abort),
    .i_delay(delay), .i_length(length), .i_test_mode(test_mode),
    .i_filter_data(filter_data), .i_filter_valid(filter_valid),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_rd_ready(rd_ready), .o_busy(busy), .o_done(done), .o_trig_lost(trig_lost)
  );

  always #5 clk = ~clk;

  // Single-port RAM model, read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (ram_we) begin
        chk("wr_had_valid", {31'd0, prev_fv}, 32'd1);
        if (exp_wr.size() == 0) fail_now("wr_unexpected");
        else chk("wr_addr_data", {9'd0, ram_addr, ram_wdata}, {9'd0, exp_wr.pop_front()});
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) fail_now("rd_unexpected");
        else chk("rd_word", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
      end
      if (done) begin
        if (exp_done == 0) fail_now("done_unexpected");
        else begin
          exp_done--;
          chk("done_busy_low", {31'd0, busy}, 32'd0);
        end
      end
    end
    prev_fv = filter_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [6:0] a, input logic [15:0] d);
    exp_wr.push_back({a, d});
    exp_rd.push_back(d);
  endtask

  task automatic start(input logic [6:0] d, input logic [6:0] len, input logic tm,
                       input logic fv0, input logic [15:0] dat0);
    delay = d; length = len; test_mode = tm;
    filter_valid = fv0; filter_data = dat0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  // Drive filter_valid every 'period' cycles (0 = none) until done; lat = cycles from trig to done.
  task automatic run_until_done(input int period, input logic [15:0] base, input int max_cyc,
                                output int lat);
    int k;
    k = 0;
    lat = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (period > 0) begin
        filter_valid = ((c % period) == (period - 1));
        if (filter_valid) k++;
        filter_data = base + 16'(k);
      end else begin
        filter_valid = 1'b0;
      end
      step();
      if (done) begin
        lat = c + 2;
        break;
      end
    end
    filter_valid = 1'b0;
    if (lat < 0) fail_now("done_timeout");
  endtask

  task automatic wait_rd_valid(input int max_cyc);
    int ok;
    ok = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (rd_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    if (ok == 0) fail_now("rd_valid_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    // Reset state.
    step(); step();
    chk("reset_outputs", {9'd0, ram_we, ram_addr, ram_wdata, rd_valid, busy, done, trig_lost},
        32'd0);
    chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    step();

    // Asynchronous reset in the middle of a capture.
    start(7'd0, 7'd7, 1'b1, 1'b1, 16'h0);
    step(); step(); step();
    chk("pre_reset_writing", {31'd0, ram_we}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {9'd0, ram_we, ram_addr, ram_wdata, rd_valid, busy, done, trig_lost}, 32'd0);
    filter_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    step();
    mon_en = 1'b1;

    // delay=3 length=7 test ramp, continuous valid: writes and reads 0..7.
    for (int i = 0; i < 8; i++) push_word(7'(i), 16'(i));
    exp_done++;
    start(7'd3, 7'd7, 1'b1, 1'b1, 16'h0);
    run_until_done(1, 16'h7700, 200, lat);

    // Sparse valid every 5th cycle, delay=2 length=3: samples 3..6 land at addr 0..3.
    push_word(7'd0, 16'h5A03);
    push_word(7'd1, 16'h5A04);
    push_word(7'd2, 16'h5A05);
    push_word(7'd3, 16'h5A06);
    exp_done++;
    start(7'd2, 7'd3, 1'b0, 1'b0, 16'h5A00);
    run_until_done(5, 16'h5A00, 300, lat);

    // Backpressure: 10 cycles without rd_ready, then a single accept.
    push_word(7'd0, 16'd0);
    push_word(7'd1, 16'd1);
    exp_done++;
    rd_ready = 1'b0;
    start(7'd0, 7'd1, 1'b1, 1'b1, 16'h0);
    filter_valid = 1'b1;
    wait_rd_valid(40);
    filter_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!rd_valid || rd_data !== 16'd0) seen++;
    end
    chk("bp_hold_stable", seen, 0);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("bp_valid_drop", {31'd0, rd_valid}, 32'd0);
    step(); step();
    chk("bp_next_valid", {31'd0, rd_valid}, 32'd1);
    chk("bp_next_word", {16'd0, rd_data}, 32'd1);
    rd_ready = 1'b1;
    run_until_done(0, 16'h0, 40, lat);

    // Trig during DELAY carrying different settings: reported and ignored.
    push_word(7'd0, 16'd0);
    push_word(7'd1, 16'd1);
    exp_done++;
    start(7'd4, 7'd1, 1'b1, 1'b0, 16'h0);
    step();
    delay = 7'd0; length = 7'd5; test_mode = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("trig_lost_pulse", {31'd0, trig_lost}, 32'd1);
    chk("trig_lost_busy", {31'd0, busy}, 32'd1);
    step();
    chk("trig_lost_single", {31'd0, trig_lost}, 32'd0);
    run_until_done(1, 16'h3300, 100, lat);

    // Abort while holding a readout word.
    exp_wr.push_back({7'd0, 16'd0});
    exp_wr.push_back({7'd1, 16'd1});
    exp_wr.push_back({7'd2, 16'd2});
    rd_ready = 1'b0;
    start(7'd0, 7'd2, 1'b1, 1'b1, 16'h0);
    filter_valid = 1'b1;
    wait_rd_valid(40);
    filter_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {30'd0, busy, rd_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen++;
      step();
    end
    chk("abort_no_done", seen, 0);
    rd_ready = 1'b1;

    // Minimum path after abort: delay=0 length=0, first valid carries ABCD.
    push_word(7'd0, 16'hABCD);
    exp_done++;
    start(7'd0, 7'd0, 1'b0, 1'b1, 16'h1111);
    run_until_done(1, 16'hABCC, 40, lat);
    chk("trig_to_done", lat, 6);
    step(); step();

    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("done_all_seen", exp_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
